ultrasonic_ranger: RTL

- Sensor front end that produces the unsigned `feedback` distance consumed by the PID controller in the wall follower.
- Drives the HC-SR04-style `trig` pulse on a fixed period and times the returned `echo` pulse.
- Converts the echo width to centimetres at PV_WIDTH bits, with a one-cycle `valid` strobe per measurement.
- Timeouts (no echo, or echo too long) saturate to MAX_DIST and raise a flag.

---
 rtl/ultrasonic_ranger.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger: HC-SR04 trigger/echo timer producing a saturating cm distance with a valid strobe.
// Optional RANGER_MEDIAN_EN: distance is the median of the last three raw results (one extra cycle latency).
module ultrasonic_ranger #(
    parameter int PV_WIDTH         = 9,
    parameter int TRIG_CYCLES      = 1000,
    parameter int CYCLES_PER_CM    = 5800,
    parameter int MAX_DIST         = 400,
    parameter int WAIT_ECHO_CYCLES = 100000,
    parameter int PERIOD_CYCLES    = 6000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                echo,
    output logic                trig,
    output logic [PV_WIDTH-1:0] distance,
    output logic                valid,
    output logic                timeout
);
    localparam int TW = $clog2(TRIG_CYCLES);
    localparam int WW = $clog2(WAIT_ECHO_CYCLES);
    localparam int SW = $clog2(CYCLES_PER_CM);
    localparam int CW = $clog2(MAX_DIST + 1);
    localparam int PW = $clog2(PERIOD_CYCLES);
    typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, HOLDOFF} state_t;
    state_t state, state_next;
    logic echo_s1, echo_s, echo_d, rise, wrap, res_valid, res_to;
    logic [TW-1:0] trig_cnt;
    logic [WW-1:0] wait_cnt;
    logic [SW-1:0] sub_cnt;
    logic [CW-1:0] cm_cnt;
    logic [PW-1:0] per_cnt;
    logic [PV_WIDTH-1:0] res_dist;
    assign rise = echo_s & ~echo_d;
    assign wrap = sub_cnt == SW'(CYCLES_PER_CM - 1);
    always_comb begin
        state_next = state;
        res_valid = 1'b0;
        res_to = 1'b0;
        res_dist = PV_WIDTH'(cm_cnt);
        if (!en) state_next = IDLE;
        else case (state)
            IDLE:    state_next = TRIG;
            TRIG:    state_next = trig_cnt == TW'(TRIG_CYCLES - 1) ? WAIT_ECHO : TRIG;
            WAIT_ECHO: begin
                if (rise) state_next = MEASURE;
                else if (wait_cnt == WW'(WAIT_ECHO_CYCLES - 1)) begin
                    state_next = HOLDOFF;
                    res_valid = 1'b1;
                    res_to = 1'b1;
                    res_dist = PV_WIDTH'(MAX_DIST);
                end
            end
            MEASURE: begin
                if (!echo_s || cm_cnt == CW'(MAX_DIST)) begin
                    state_next = HOLDOFF;
                    res_valid = 1'b1;
                    res_to = echo_s;
                end
            end
            HOLDOFF: state_next = per_cnt == PW'(PERIOD_CYCLES - 1) && !echo_s ? TRIG : HOLDOFF;
            default: state_next = IDLE;
        endcase
    end
    // the rising-edge cycle itself is the first counted echo-high cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            {echo_s1, echo_s, echo_d, trig} <= '0;
            trig_cnt <= '0;
            wait_cnt <= '0;
            sub_cnt <= '0;
            cm_cnt <= '0;
            per_cnt <= '0;
        end else begin
            state <= state_next;
            {echo_s1, echo_s, echo_d} <= {echo, echo_s1, echo_s};
            trig <= state_next == TRIG;
            trig_cnt <= state == TRIG ? trig_cnt + 1'b1 : '0;
            wait_cnt <= state == WAIT_ECHO ? wait_cnt + 1'b1 : '0;
            per_cnt <= state_next == TRIG && state != TRIG ? '0 :
                       per_cnt == PW'(PERIOD_CYCLES - 1) ? per_cnt : per_cnt + 1'b1;
            if (state == WAIT_ECHO) begin
                sub_cnt <= SW'(1);
                cm_cnt <= '0;
            end else if (state == MEASURE && echo_s) begin
                sub_cnt <= wrap ? '0 : sub_cnt + 1'b1;
                cm_cnt <= cm_cnt + CW'(wrap);
            end
        end
    end
`ifdef RANGER_MEDIAN_EN
    logic [PV_WIDTH-1:0] h0, h1, h2, lo, hi, med;
    logic v1, t1;
    always_comb begin
        lo = h0 < h1 ? h0 : h1;
        hi = h0 < h1 ? h1 : h0;
        med = hi < h2 ? hi : (lo > h2 ? lo : h2);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            {h0, h1, h2, distance} <= '0;
            {v1, t1, valid, timeout} <= '0;
        end else begin
            v1 <= res_valid;
            t1 <= res_to;
            if (res_valid) {h2, h1, h0} <= {h1, h0, res_dist};
            valid <= v1;
            if (v1) begin
                distance <= med;
                timeout <= t1;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            distance <= '0;
            {valid, timeout} <= '0;
        end else begin
            valid <= res_valid;
            if (res_valid) begin
                distance <= res_dist;
                timeout <= res_to;
            end
        end
    end
`endif
endmodule
